// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 8-way arbiter family: state encoding, sizes
// and a small one-hot helper.
package mux_arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_e;

    function automatic logic [NUM_REQ-1:0] to_onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational circular priority picker: the first set request bit at or
// after last+1 (mod 8) wins.
module rr_pick8
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic [SEL_W-1:0]   idx,
    output logic               found
);

    logic [SEL_W-1:0] probe;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        probe = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            probe = last + SEL_W'(k);
            if (!found && req[probe]) begin
                found = 1'b1;
                idx   = probe;
            end
        end
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter owning the select lines of an 8:1 bit mux, with
// bounded hold time under contention and a registered data output.
module mux8_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] d,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic               dout,
    output logic               dout_vld
);

    localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

    arb_state_e         state, state_n;
    logic [SEL_W-1:0]   last, last_n;
    logic [7:0]         hold_cnt, hold_cnt_n;
    logic [NUM_REQ-1:0] gnt_n;
    logic [SEL_W-1:0]   sel_n;
    logic               busy_n, dout_n, dout_vld_n;

    logic [SEL_W-1:0]   pick_idx;
    logic               pick_found;
    logic               release_hit, preempt_hit;

    rr_pick8 u_pick (
        .req   (req),
        .last  (last),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign release_hit = !req[sel];
    assign preempt_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) && ((req & ~gnt) != '0);

    always_comb begin
        state_n    = state;
        last_n     = last;
        hold_cnt_n = hold_cnt;
        gnt_n      = gnt;
        sel_n      = sel;
        busy_n     = busy;
        dout_n     = busy ? d[sel] : 1'b0;
        dout_vld_n = busy;

        case (state)
            IDLE, TURN: begin
                if (pick_found) begin
                    state_n    = GRANT;
                    gnt_n      = to_onehot(pick_idx);
                    sel_n      = pick_idx;
                    last_n     = pick_idx;
                    busy_n     = 1'b1;
                    hold_cnt_n = '0;
                end else begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    busy_n  = 1'b0;
                end
            end
            GRANT: begin
                // A release at the preemption threshold lands in TURN either way.
                if (release_hit || preempt_hit) begin
                    state_n = TURN;
                    gnt_n   = '0;
                    busy_n  = 1'b0;
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_cnt_n = hold_cnt + 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= 3'd7;
            hold_cnt <= '0;
            gnt      <= '0;
            sel      <= '0;
            busy     <= 1'b0;
            dout     <= 1'b0;
            dout_vld <= 1'b0;
        end else begin
            state    <= state_n;
            last     <= last_n;
            hold_cnt <= hold_cnt_n;
            gnt      <= gnt_n;
            sel      <= sel_n;
            busy     <= busy_n;
            dout     <= dout_n;
            dout_vld <= dout_vld_n;
        end
    end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Bench for mux8_rr_arbiter: a cycle-level reference model fills an expected
// queue each edge; outputs are popped and compared on the falling edge.
module tb_mux8_rr_arbiter;

    localparam int M = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = '0;
    logic [7:0] d = '0;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy, dout, dout_vld;

    int n_checks = 0;
    int n_pass   = 0;

    logic [13:0] exp_q[$];

    // reference model state
    int         m_state;  // 0 idle, 1 grant, 2 turn
    logic [7:0] m_gnt;
    logic [2:0] m_sel;
    logic       m_busy, m_dout, m_vld;
    int         m_held;   // cycles the current grant has been visible
    int         m_last;

    mux8_rr_arbiter #(.MAX_HOLD(M)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .d        (d),
        .gnt      (gnt),
        .sel      (sel),
        .busy     (busy),
        .dout     (dout),
        .dout_vld (dout_vld)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [13:0] outs();
        return {gnt, sel, busy, dout, dout_vld};
    endfunction

    task automatic model_reset();
        m_state = 0; m_gnt = '0; m_sel = '0; m_busy = 0;
        m_dout = 0; m_vld = 0; m_held = 0; m_last = 7;
    endtask

    task automatic model_step(input logic [7:0] r, input logic [7:0] dv);
        int  w;
        bit  hit;
        m_dout = m_busy ? dv[m_sel] : 1'b0;
        m_vld  = m_busy;
        if (m_state == 1) begin
            if (!r[m_sel] || (M != 0 && m_held >= M && (r & ~m_gnt) != 0)) begin
                m_state = 2; m_gnt = '0; m_busy = 0;
            end else if (m_held < 1000) begin
                m_held++;
            end
        end else begin
            hit = 0; w = 0;
            for (int k = 1; k <= 8; k++)
                if (!hit && r[(m_last + k) % 8]) begin hit = 1; w = (m_last + k) % 8; end
            if (hit) begin
                m_state = 1; m_gnt = 8'(1 << w); m_sel = 3'(w);
                m_last = w; m_busy = 1; m_held = 1;
            end else begin
                m_state = 0; m_gnt = '0; m_busy = 0;
            end
        end
    endtask

    task automatic cycle(input logic [7:0] r, input logic [7:0] dv);
        req = r;
        d   = dv;
        @(posedge clk);
        model_step(r, dv);
        exp_q.push_back({m_gnt, m_sel, m_busy, m_dout, m_vld});
        @(negedge clk);
        if (exp_q.size() == 0) check("queue_empty", 32'd1, 32'd0);
        else check("outputs", 32'(outs()), 32'(exp_q.pop_front()));
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_outs", 32'(outs()), 32'd0);
        rst_n = 1'b1;

        // idle with no requests
        for (int i = 0; i < 10; i++) cycle(8'h00, 8'($urandom_range(0, 255)));
        check("idle_sel", 32'(sel), 32'd0);

        // two requesters from reset: 0 first, then 7 after a turnaround
        cycle(8'h81, 8'h00);
        check("first_gnt", 32'(gnt), 32'h01);
        for (int i = 0; i < 3; i++) cycle(8'h81, 8'h01);
        cycle(8'h80, 8'h80);
        check("turn_gnt", 32'(gnt), 32'h00);
        cycle(8'h80, 8'h80);
        check("second_gnt", 32'(gnt), 32'h80);
        for (int i = 0; i < 3; i++) cycle(8'h80, 8'h80);
        for (int i = 0; i < 4; i++) cycle(8'h00, 8'h00);

        // full contention: rotation 0..7,0 with 4-cycle grants
        for (int i = 0; i < 45; i++) cycle(8'hFF, 8'($urandom_range(0, 255)));
        for (int i = 0; i < 3; i++) cycle(8'h00, 8'h00);

        // lone requester is never preempted
        for (int i = 0; i < 50; i++) cycle(8'h10, 8'($urandom_range(0, 255)));
        check("lone_gnt", 32'(gnt), 32'h10);
        for (int i = 0; i < 3; i++) cycle(8'h00, 8'h00);

        // data path on requester 2
        for (int i = 0; i < 3; i++) cycle(8'h04, 8'h04);
        check("dout_hi", 32'(dout), 32'd1);
        cycle(8'h04, 8'h00);
        check("dout_lo", 32'(dout), 32'd0);
        for (int i = 0; i < 3; i++) cycle(8'h00, 8'hFF);
        check("vld_drop", 32'(dout_vld), 32'd0);

        // random traffic
        for (int i = 0; i < 300; i++)
            cycle(8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)));
        for (int i = 0; i < 3; i++) cycle(8'h00, 8'h00);

        // asynchronous reset in the middle of a grant
        for (int i = 0; i < 3; i++) cycle(8'h08, 8'hFF);
        check("pre_rst_gnt", 32'(gnt), 32'h08);
        #2 rst_n = 1'b0;
        #1 check("async_rst", 32'(outs()), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(8'hFF, 8'h00);
        check("post_rst_gnt", 32'(gnt), 32'h01);
        for (int i = 0; i < 10; i++) cycle(8'hFF, 8'($urandom_range(0, 255)));

        if (exp_q.size() != 0) check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
